// File: rtl/prompt_sequencer.sv
// Switch-game round controller: LFSR target pick, per-round countdown, pass/fail.
// Optional PROMPT_SPEEDUP_EN shortens the round time as more rounds are passed.
module prompt_sequencer #(
    parameter int          NUM_SW    = 10,
    parameter int          ROUND_S   = 15,
    parameter int          GAP_S     = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset_btn_n,
    input  logic              tick,
    input  logic              start,
    input  logic [NUM_SW-1:0] sw,
    output logic [NUM_SW-1:0] ledr,
    output logic [5:0]        count,
    output logic              round_active,
    output logic              round_pass,
    output logic              round_fail,
    output logic [6:0]        round_num
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_PLAY,
        S_GAP,
        S_OVER
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [3:0]        tgt_q, tgt_d;
    logic [5:0]        count_q, count_d;
    logic [6:0]        rnum_q, rnum_d;
    logic [NUM_SW-1:0] ledr_q, ledr_d;
    logic              active_q, active_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;

    logic [3:0]        cand;
    logic [NUM_SW-1:0] cand_hot;
    logic [NUM_SW-1:0] tgt_hot;
    logic [5:0]        round_time;

    function automatic logic [NUM_SW-1:0] onehot(input logic [3:0] i);
        return NUM_SW'(1) << i;
    endfunction

`ifdef PROMPT_SPEEDUP_EN
    logic [6:0] dec;
    assign dec = rnum_q / 7'd5;
    assign round_time = (7'(ROUND_S) >= dec + 7'd5) ?
                        6'(7'(ROUND_S) - dec) : 6'd5;
`else
    assign round_time = 6'(ROUND_S);
`endif

    assign cand     = lfsr_q[3:0];
    assign cand_hot = onehot(cand);
    assign tgt_hot  = onehot(tgt_q);

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        count_d = count_q;
        rnum_d  = rnum_q;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        lfsr_d  = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARM;
                    rnum_d  = '0;
                end
            end
            S_ARM: begin
                if (({1'b0, cand} < 5'(NUM_SW)) && (sw != cand_hot)) begin
                    tgt_d   = cand;
                    count_d = round_time;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                // An exact match wins even on the cycle the timer hits zero.
                if (sw == tgt_hot) begin
                    pass_d  = 1'b1;
                    rnum_d  = (rnum_q == 7'd99) ? rnum_q : rnum_q + 7'd1;
                    count_d = 6'(GAP_S);
                    state_d = S_GAP;
                end else if (count_q == '0) begin
                    fail_d  = 1'b1;
                    state_d = S_OVER;
                end else if (tick) begin
                    count_d = count_q - 6'd1;
                end
            end
            S_GAP: begin
                if (count_q == '0) begin
                    state_d = S_ARM;
                end else if (tick) begin
                    count_d = count_q - 6'd1;
                end
            end
            S_OVER: begin
                count_d = '0;
                if (start) begin
                    state_d = S_ARM;
                    rnum_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        unique case (state_d)
            S_PLAY:  ledr_d = onehot(tgt_d);
            S_OVER:  ledr_d = '1;
            default: ledr_d = '0;
        endcase
        active_d = (state_d == S_PLAY);
    end

    always_ff @(posedge clk or negedge reset_btn_n) begin
        if (!reset_btn_n) begin
            state_q  <= S_IDLE;
            lfsr_q   <= LFSR_SEED;
            tgt_q    <= '0;
            count_q  <= '0;
            rnum_q   <= '0;
            ledr_q   <= '0;
            active_q <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            tgt_q    <= tgt_d;
            count_q  <= count_d;
            rnum_q   <= rnum_d;
            ledr_q   <= ledr_d;
            active_q <= active_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

    assign ledr         = ledr_q;
    assign count        = count_q;
    assign round_active = active_q;
    assign round_pass   = pass_q;
    assign round_fail   = fail_q;
    assign round_num    = rnum_q;

endmodule
